spi_frame_sequencer: RTL and testbench

//  Sits between spi_slave and the stepgen/pwm/DOUT datapath. Validates each received SPI

---
 rtl/spi_frame_if.sv | 26 ++
 rtl/spi_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_if.sv
// Frame bus between spi_slave and the frame sequencer: the received frame with
// its completion strobe, and the committed command frame with its update pulse.
interface spi_frame_if #(
   parameter int BUFFER_SIZE = 240
);
   logic [BUFFER_SIZE-1:0] rx_data;
   logic                   rx_strobe;
   logic [BUFFER_SIZE-1:0] cmd_frame;
   logic                   cmd_update;

   // Frame source side (spi_slave / stimulus)
   modport master (
      output rx_data,
      output rx_strobe,
      input  cmd_frame,
      input  cmd_update
   );

   // Frame sequencer side
   modport slave (
      input  rx_data,
      input  rx_strobe,
      output cmd_frame,
      output cmd_update
   );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Frame sequencer: validates SPI frames by header, commits WRITE frames to the
// command register, runs the link watchdog and the RUN/FAULT/ESTOP machine that
// gates joint enables and selects the reply header.
module spi_frame_sequencer #(
   parameter int          BUFFER_SIZE  = 240,
   parameter logic [31:0] WRITE_HDR    = 32'h74697277,
   parameter logic [31:0] READ_HDR     = 32'h64616572,
   parameter logic [31:0] DATA_HDR     = 32'h64617461,
   parameter logic [31:0] ESTP_HDR     = 32'h65737470,
   parameter int          TIMEOUT_CLKS = 4800000
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_frame_if.slave  bus,
   input  logic        estop_in,
   output logic        run_ok,
   output logic        pkg_timeout,
   output logic        estop,
   output logic [31:0] header_tx,
   output logic [15:0] frame_count,
   output logic [15:0] bad_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2,
      ST_ESTOP = 2'd3
   } state_e;

   localparam int              WD_W    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CLKS);

   state_e                 state_q, state_d;
   logic                   est_meta_q, est_s_q;
   logic                   strobe_q;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [BUFFER_SIZE-1:0] cmd_frame_q, cmd_frame_d;
   logic                   cmd_update_q, cmd_update_d;
   logic [15:0]            frame_count_q, frame_count_d;
   logic [15:0]            bad_count_q, bad_count_d;
   logic                   run_ok_q, run_ok_d;
   logic                   pkg_timeout_q, pkg_timeout_d;
   logic                   estop_q, estop_d;
   logic [31:0]            header_tx_q, header_tx_d;

   // Header is the top 32 bits of the frame, byte-reversed.
   logic [31:0] hdr_top, header_rx;
   logic        frame_evt, wr_frame, rd_frame, bad_frame, valid_frame;

   assign hdr_top     = bus.rx_data[BUFFER_SIZE-1 -: 32];
   assign header_rx   = {hdr_top[7:0], hdr_top[15:8], hdr_top[23:16], hdr_top[31:24]};
   assign frame_evt   = bus.rx_strobe & ~strobe_q;
   assign wr_frame    = frame_evt & (header_rx == WRITE_HDR);
   assign rd_frame    = frame_evt & (header_rx == READ_HDR);
   assign bad_frame   = frame_evt & ~wr_frame & ~rd_frame;
   assign valid_frame = wr_frame | rd_frame;

   // Next-state logic and registered state-decoded outputs.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d = state_q;
      if (est_s_q) begin
         state_d = ST_ESTOP;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAULT, ST_ESTOP: if (wr_frame) state_d = ST_RUN;
            ST_RUN: if (!valid_frame && (wd_q == WD_LAST)) state_d = ST_FAULT;
            default: state_d = ST_IDLE;
         endcase
      end
      run_ok_d      = (state_d == ST_RUN);
      pkg_timeout_d = (state_d == ST_IDLE) || (state_d == ST_FAULT);
      estop_d       = (state_d == ST_ESTOP);
      header_tx_d   = (state_d == ST_ESTOP) ? ESTP_HDR : DATA_HDR;
   end

   // Command commit, frame counters and link watchdog.
   always_comb begin
      cmd_frame_d   = cmd_frame_q;
      cmd_update_d  = wr_frame;
      frame_count_d = frame_count_q;
      bad_count_d   = bad_count_q;
      wd_d          = wd_q;
      if (wr_frame) begin
         cmd_frame_d   = bus.rx_data;
         frame_count_d = frame_count_q + 16'd1;
      end
      if (bad_frame && (bad_count_q != 16'hFFFF)) begin
         bad_count_d = bad_count_q + 16'd1;
      end
      // Watchdog restarts on any valid frame and on every entry into RUN.
      if (valid_frame || ((state_d == ST_RUN) && (state_q != ST_RUN))) begin
         wd_d = '0;
      end else if ((state_q == ST_RUN) && (wd_q != WD_MAX)) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   // State, datapath and synchronizer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         est_meta_q    <= 1'b0;
         est_s_q       <= 1'b0;
         // Reset to 1 so a strobe still high at reset release is not taken as a new edge.
         strobe_q      <= 1'b1;
         wd_q          <= '0;
         cmd_frame_q   <= '0;
         cmd_update_q  <= 1'b0;
         frame_count_q <= 16'd0;
         bad_count_q   <= 16'd0;
         run_ok_q      <= 1'b0;
         pkg_timeout_q <= 1'b1;
         estop_q       <= 1'b0;
         header_tx_q   <= DATA_HDR;
      end else begin
         state_q       <= state_d;
         est_meta_q    <= estop_in;
         est_s_q       <= est_meta_q;
         strobe_q      <= bus.rx_strobe;
         wd_q          <= wd_d;
         cmd_frame_q   <= cmd_frame_d;
         cmd_update_q  <= cmd_update_d;
         frame_count_q <= frame_count_d;
         bad_count_q   <= bad_count_d;
         run_ok_q      <= run_ok_d;
         pkg_timeout_q <= pkg_timeout_d;
         estop_q       <= estop_d;
         header_tx_q   <= header_tx_d;
      end
   end

   assign bus.cmd_frame  = cmd_frame_q;
   assign bus.cmd_update = cmd_update_q;
   assign run_ok         = run_ok_q;
   assign pkg_timeout    = pkg_timeout_q;
   assign estop          = estop_q;
   assign header_tx      = header_tx_q;
   assign frame_count    = frame_count_q;
   assign bad_count      = bad_count_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: directed scenarios plus random
// frame/e-stop traffic, compared every cycle against a behavioural model.
module tb_spi_frame_sequencer;

   localparam int          BS        = 240;
   localparam int          T         = 1000;
   localparam logic [31:0] WRITE_HDR = 32'h74697277;
   localparam logic [31:0] READ_HDR  = 32'h64616572;
   localparam logic [31:0] DATA_HDR  = 32'h64617461;
   localparam logic [31:0] ESTP_HDR  = 32'h65737470;
   localparam logic [31:0] BAD_HDR   = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        estop_in = 1'b0;
   logic        run_ok, pkg_timeout, estop;
   logic [31:0] header_tx;
   logic [15:0] frame_count, bad_count;

   spi_frame_if #(.BUFFER_SIZE(BS)) bus ();

   spi_frame_sequencer #(.BUFFER_SIZE(BS), .TIMEOUT_CLKS(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .estop_in    (estop_in),
      .run_ok      (run_ok),
      .pkg_timeout (pkg_timeout),
      .estop       (estop),
      .header_tx   (header_tx),
      .frame_count (frame_count),
      .bad_count   (bad_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] header_of(input logic [BS-1:0] f);
      return {f[BS-25:BS-32], f[BS-17:BS-24], f[BS-9:BS-16], f[BS-1:BS-8]};
   endfunction

   function automatic logic [BS-1:0] make_frame(input logic [31:0] hdr);
      logic [BS-1:0] f;
      for (int i = 0; i < BS; i += 16) f[i +: 16] = 16'($urandom);
      f[BS-25:BS-32] = hdr[31:24];
      f[BS-17:BS-24] = hdr[23:16];
      f[BS-9:BS-16]  = hdr[15:8];
      f[BS-1:BS-8]   = hdr[7:0];
      return f;
   endfunction

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_FAULT, M_ESTOP} mstate_e;
   mstate_e           m_state = M_IDLE;
   logic [BS-1:0]     m_cmd = '0;
   logic              m_upd = 1'b0;
   logic [15:0]       m_fc = 16'd0, m_bc = 16'd0;
   logic              s1 = 1'b0, s2 = 1'b0, prev_stb = 1'b1;
   longint unsigned   cyc = 0, clear_mark = 0;

   // Model steps on every clock edge; the watchdog is the cycle distance from the
   // last clear point (RUN entry or valid frame).
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_state = M_IDLE; m_cmd = '0; m_upd = 1'b0; m_fc = 16'd0; m_bc = 16'd0;
            s1 = 1'b0; s2 = 1'b0; prev_stb = 1'b1; clear_mark = cyc;
         end else begin
            logic evt, est, is_w, is_r, is_b, expired;
            logic [31:0] hdr;
            mstate_e old;
            evt = bus.rx_strobe && !prev_stb;
            prev_stb = bus.rx_strobe;
            est = s2; s2 = s1; s1 = estop_in;
            hdr = header_of(bus.rx_data);
            is_w = evt && (hdr == WRITE_HDR);
            is_r = evt && (hdr == READ_HDR);
            is_b = evt && !is_w && !is_r;
            expired = (m_state == M_RUN) && ((cyc - clear_mark) >= 64'(T - 1)) && !(is_w || is_r);
            old = m_state;
            if (est)          m_state = M_ESTOP;
            else if (is_w)    m_state = M_RUN;
            else if (expired) m_state = M_FAULT;
            if (is_w || is_r || (m_state == M_RUN && old != M_RUN)) clear_mark = cyc + 1;
            m_upd = is_w;
            if (is_w) begin m_cmd = bus.rx_data; m_fc = m_fc + 16'd1; end
            if (is_b && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
         end
         if (clk) cyc++;
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_frame",   256'(bus.cmd_frame),  256'(m_cmd));
         check("cmd_update",  256'(bus.cmd_update), 256'(m_upd));
         check("run_ok",      256'(run_ok),         256'(m_state == M_RUN));
         check("pkg_timeout", 256'(pkg_timeout),    256'(m_state == M_IDLE || m_state == M_FAULT));
         check("estop",       256'(estop),          256'(m_state == M_ESTOP));
         check("header_tx",   256'(header_tx),      256'((m_state == M_ESTOP) ? ESTP_HDR : DATA_HDR));
         check("frame_count", 256'(frame_count),    256'(m_fc));
         check("bad_count",   256'(bad_count),      256'(m_bc));
      end
   end

   // Raise strobe with frame f for 'hold' cycles; returns just after the first
   // post-commit negedge when hold=1.
   task automatic drive_frame(input logic [BS-1:0] f, input int hold);
      @(negedge clk); #1;
      bus.rx_data   = f;
      bus.rx_strobe = 1'b1;
      repeat (hold) @(negedge clk);
      #1 bus.rx_strobe = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: bench still running at %0t", $time);
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      logic [BS-1:0] f;
      logic [15:0]   fc_save;
      bus.rx_data   = '0;
      bus.rx_strobe = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_run_ok",      256'(run_ok),      256'(0));
      check("rst_pkg_timeout", 256'(pkg_timeout), 256'(1));
      check("rst_header_tx",   256'(header_tx),   256'(DATA_HDR));
      check("rst_frame_count", 256'(frame_count), 256'(0));
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: first WRITE frame commits and enters RUN
      f = make_frame(WRITE_HDR);
      f[BS-33 -: 32] = 32'h00001000;
      drive_frame(f, 1);
      check("t1_cmd_frame",   256'(bus.cmd_frame),  256'(f));
      check("t1_cmd_update",  256'(bus.cmd_update), 256'(1));
      check("t1_run_ok",      256'(run_ok),         256'(1));
      check("t1_pkg_timeout", 256'(pkg_timeout),    256'(0));
      check("t1_frame_count", 256'(frame_count),    256'(1));

      // 2: no frames -> FAULT exactly TIMEOUT_CLKS after RUN entry, then recover
      repeat (T - 1) @(negedge clk);
      check("t2_run_before", 256'(run_ok), 256'(1));
      @(negedge clk);
      check("t2_run_fault",  256'(run_ok),      256'(0));
      check("t2_pkg_fault",  256'(pkg_timeout), 256'(1));
      drive_frame(make_frame(WRITE_HDR), 1);
      check("t2_recover", 256'(run_ok), 256'(1));

      // 3: READ polls every 900 clk keep RUN alive without committing
      fc_save = frame_count;
      for (int i = 0; i < 6; i++) begin
         repeat (898) @(negedge clk);
         drive_frame(make_frame(READ_HDR), 1);
      end
      check("t3_run_ok",      256'(run_ok),      256'(1));
      check("t3_frame_count", 256'(frame_count), 256'(fc_save));

      // 4: bad headers count but do not feed the watchdog
      drive_frame(make_frame(WRITE_HDR), 1);
      for (int i = 0; i < 3; i++) begin
         repeat (200) @(negedge clk);
         drive_frame(make_frame(BAD_HDR), 1);
      end
      check("t4_bad_count", 256'(bad_count), 256'(3));
      repeat (393) @(negedge clk);
      check("t4_run_before", 256'(run_ok), 256'(1));
      @(negedge clk);
      check("t4_run_fault", 256'(run_ok), 256'(0));
      @(negedge clk); #1;
      force dut.bad_count_q = 16'hFFFE;
      m_bc = 16'hFFFE;
      @(negedge clk); #1;
      release dut.bad_count_q;
      for (int i = 0; i < 3; i++) drive_frame(make_frame(BAD_HDR), 1);
      check("t4_bad_sat", 256'(bad_count), 256'(16'hFFFF));

      // 5: e-stop during RUN, commit while held, recover after release
      drive_frame(make_frame(WRITE_HDR), 1);
      @(negedge clk); #3 estop_in = 1'b1;
      repeat (2) @(negedge clk);
      check("t5_estop_early", 256'(estop), 256'(0));
      @(negedge clk);
      check("t5_estop",     256'(estop),     256'(1));
      check("t5_header_tx", 256'(header_tx), 256'(32'h65737470));
      check("t5_run_ok",    256'(run_ok),    256'(0));
      fc_save = frame_count;
      drive_frame(make_frame(WRITE_HDR), 1);
      check("t5_commit_in_estop", 256'(frame_count), 256'(fc_save + 16'd1));
      check("t5_stay_estop",      256'(estop),       256'(1));
      @(negedge clk); #2 estop_in = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_still_estop", 256'(estop), 256'(1));
      drive_frame(make_frame(WRITE_HDR), 1);
      check("t5_back_run", 256'(run_ok), 256'(1));

      // 6: held strobe with reset pulse in the middle
      do_reset();
      repeat (2) @(negedge clk);
      @(negedge clk); #1;
      bus.rx_data   = make_frame(WRITE_HDR);
      bus.rx_strobe = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_one_commit", 256'(frame_count), 256'(1));
      #1 rst_n = 1'b0;
      #1 check("t6_reset_now", 256'(frame_count), 256'(0));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_no_commit_held", 256'(frame_count), 256'(0));
      check("t6_cmd_frame_zero", 256'(bus.cmd_frame), 256'(0));
      #1 bus.rx_strobe = 1'b0;
      @(negedge clk);
      drive_frame(make_frame(WRITE_HDR), 1);
      check("t6_new_edge", 256'(frame_count), 256'(1));

      // Random traffic
      do_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         int k;
         logic [31:0] h;
         k = int'($urandom_range(0, 19));
         if (k < 7) begin
            drive_frame(make_frame(WRITE_HDR), int'($urandom_range(1, 3)));
         end else if (k < 11) begin
            drive_frame(make_frame(READ_HDR), int'($urandom_range(1, 3)));
         end else if (k < 15) begin
            h = $urandom;
            if (h == WRITE_HDR || h == READ_HDR) h = BAD_HDR;
            drive_frame(make_frame(h), int'($urandom_range(1, 3)));
         end else if (k < 18) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
         end else if (k == 18) begin
            @(negedge clk);
            #($urandom_range(1, 4)) estop_in = ($urandom_range(0, 3) == 0);
         end else begin
            repeat ($urandom_range(900, 1100)) @(negedge clk);
         end
      end
      estop_in = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
